// File: rtl/usb_crc16_tx_ctrl.sv
// ---------------------------------------------------------------------------
// usb_crc16_tx_ctrl
//
// This block serialises a packet of bytes, sending each byte LSB first. It
// then appends the CRC-16/USB of the payload, low CRC byte first, and
// signals end of packet with a one-cycle pulse.
//
// Serial activity advances only in cycles where the bit_en strobe is 1. At a
// byte boundary the next byte must already be waiting. If it is missing, the
// block flags an underrun and drops the packet.
//
// Optional feature:
//   When CRC16_CHECK_EN is defined, the block adds a loopback CRC checker.
//   The checker runs the same CRC over a received bit stream. At rx_eop it
//   reports whether the residue matches the CRC-16/USB good-packet value.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bit_en     in   bit-rate strobe; serial state advances only when 1
//   in_data    in   [7:0] payload byte
//   in_valid   in   in_data valid
//   in_last    in   in_data is the final payload byte
//   in_ready   out  byte accepted this cycle when in_valid is also 1
//   abort      in   synchronous abort of the packet in flight
//   rx_bit     in   (CRC16_CHECK_EN) received serial bit
//   rx_valid   in   (CRC16_CHECK_EN) rx_bit is new this cycle
//   rx_eop     in   (CRC16_CHECK_EN) end of received packet
//   crc_ok     out  (CRC16_CHECK_EN) 1-cycle pulse: residue good
//   crc_err    out  (CRC16_CHECK_EN) 1-cycle pulse: residue bad
//   tx_bit     out  serial data bit, registered
//   tx_valid   out  tx_bit is new this cycle, registered
//   tx_eop     out  1-cycle pulse after the final CRC bit
//   underrun   out  1-cycle pulse when the next byte is missing at a boundary
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module usb_crc16_tx_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       abort,
`ifdef CRC16_CHECK_EN
    input  logic       rx_bit,
    input  logic       rx_valid,
    input  logic       rx_eop,
    output logic       crc_ok,
    output logic       crc_err,
`endif
    output logic       tx_bit,
    output logic       tx_valid,
    output logic       tx_eop,
    output logic       underrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    // One step of the reflected CRC-16/USB register (poly 0x8005 -> 0xA001).
    function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic din);
        return (cur >> 1) ^ (((cur[0] ^ din) != 1'b0) ? 16'hA001 : 16'h0000);
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic        last_q, last_d;
    logic [15:0] r_q, r_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] c_q, c_d;
    // Bit 4 set means all 16 CRC bits are out and tx_eop is due next edge.
    logic [4:0]  crc_cnt_q, crc_cnt_d;
    logic        tx_bit_d, tx_valid_d, tx_eop_d, underrun_d;
    logic [15:0] r_bit;

    assign busy  = (state_q != IDLE);
    assign r_bit = crc_step(r_q, sh_q[0]);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        last_d     = last_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        crc_cnt_d  = crc_cnt_q;
        tx_bit_d   = tx_bit;
        tx_valid_d = 1'b0;
        tx_eop_d   = 1'b0;
        underrun_d = 1'b0;
        in_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sh_d    = in_data;
                    last_d  = in_last;
                    r_d     = 16'hFFFF;
                    cnt_d   = 3'd0;
                    state_d = DATA;
                end
            end

            DATA: begin
                if (bit_en) begin
                    tx_bit_d   = sh_q[0];
                    tx_valid_d = 1'b1;
                    r_d        = r_bit;
                    sh_d       = {1'b0, sh_q[7:1]};
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (last_q) begin
                            // The CRC covers the bit sent in this same cycle.
                            state_d   = CRC;
                            c_d       = ~r_bit;
                            crc_cnt_d = 5'd0;
                        end else begin
                            // Next byte loads on the boundary with no bit gap.
                            in_ready = 1'b1;
                            if (in_valid) begin
                                sh_d   = in_data;
                                last_d = in_last;
                            end else begin
                                underrun_d = 1'b1;
                                state_d    = IDLE;
                            end
                        end
                    end
                end
            end

            CRC: begin
                if (crc_cnt_q[4]) begin
                    tx_eop_d = 1'b1;
                    state_d  = IDLE;
                end else if (bit_en) begin
                    tx_bit_d   = c_q[0];
                    tx_valid_d = 1'b1;
                    c_d        = {1'b0, c_q[15:1]};
                    crc_cnt_d  = crc_cnt_q + 5'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a byte load in the same cycle.
        if (abort) begin
            state_d    = IDLE;
            sh_d       = 8'h00;
            last_d     = 1'b0;
            r_d        = 16'hFFFF;
            cnt_d      = 3'd0;
            c_d        = 16'h0000;
            crc_cnt_d  = 5'd0;
            tx_bit_d   = 1'b0;
            tx_valid_d = 1'b0;
            tx_eop_d   = 1'b0;
            underrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sh_q      <= 8'h00;
            last_q    <= 1'b0;
            r_q       <= 16'hFFFF;
            cnt_q     <= 3'd0;
            c_q       <= 16'h0000;
            crc_cnt_q <= 5'd0;
            tx_bit    <= 1'b0;
            tx_valid  <= 1'b0;
            tx_eop    <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            last_q    <= last_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            c_q       <= c_d;
            crc_cnt_q <= crc_cnt_d;
            tx_bit    <= tx_bit_d;
            tx_valid  <= tx_valid_d;
            tx_eop    <= tx_eop_d;
            underrun  <= underrun_d;
        end
    end

`ifdef CRC16_CHECK_EN
    // Loopback checker. chk_fresh_q marks that the next rx_valid starts a new
    // packet, so the register restarts from 0xFFFF on that bit.
    logic [15:0] chk_q;
    logic        chk_fresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q       <= 16'hFFFF;
            chk_fresh_q <= 1'b1;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
        end else begin
            crc_ok  <= rx_eop && (chk_q == 16'hB001);
            crc_err <= rx_eop && (chk_q != 16'hB001);
            if (rx_valid) begin
                chk_q <= crc_step(chk_fresh_q ? 16'hFFFF : chk_q, rx_bit);
            end
            if (rx_eop || (state_q == IDLE)) begin
                chk_fresh_q <= 1'b1;
            end else if (rx_valid) begin
                chk_fresh_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/usb_crc16_tx_ctrl.md
USB_CRC16_TX_CTRL -- requirements
Module: usb_crc16_tx_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- bit_en  in  1  bit-rate strobe; serial state advances only in cycles where it is 1.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  in_data is the final payload byte.
- in_ready  out  1  byte accepted this cycle when in_valid is also 1.
- abort  in  1  synchronous abort of the packet in flight.
- tx_bit  out  1  serial data bit, registered.
- tx_valid  out  1  tx_bit is new this cycle, registered.
- tx_eop  out  1  1-cycle pulse after the final CRC bit.
- underrun  out  1  1-cycle pulse when the next byte is missing at a byte boundary.
- busy  out  1  state is not IDLE.
REQ-003 The block SHALL have no parameters; the byte width is fixed at 8.

Function
REQ-004 The CRC SHALL be CRC-16/USB: polynomial 0x8005, init 0xFFFF, reflected in and out, xorout 0xFFFF, kept as a reflected 16-bit register r; per bit b: fb=r[0]^b, r=(r>>1)^(fb?0xA001:0).
REQ-005 States SHALL be IDLE, DATA and CRC.
REQ-006 IDLE: in_ready=1; on in_valid, load the byte into an 8-bit shift register, latch in_last, set r=0xFFFF, clear the bit count, and go to DATA.
REQ-007 DATA, on each bit_en: tx_bit<=sh[0] (LSB first), tx_valid<=1, update r with sh[0], shift sh right, and increment the 3-bit count.
REQ-008 In cycles with bit_en=0, tx_valid SHALL be 0 and tx_bit SHALL hold its value.
REQ-009 At DATA with count=7 and bit_en=1, if the latched last is 0, in_ready SHALL be 1 combinationally, and if in_valid is also 1, the next byte SHALL load with no bit gap.
REQ-010 In that same case with in_valid=0, the block SHALL pulse underrun, emit no further bits and no tx_eop, and return to IDLE.
REQ-011 At DATA with count=7 and bit_en=1 and the latched last=1, the block SHALL go to CRC with c = ~r taken after the final data bit.
REQ-012 CRC: on each of 16 bit_en cycles, tx_bit<=c[0], tx_valid<=1, shift c right; this sends the low byte first, LSB first.
REQ-013 After the 16th CRC bit, tx_eop SHALL pulse in the next cycle and the state SHALL return to IDLE.
REQ-014 in_ready SHALL be 0 in all cases other than those in REQ-006 and REQ-009.
REQ-015 abort=1 in any state SHALL force IDLE on the next edge with tx_valid=0, no tx_eop and no underrun pulse; abort SHALL take priority over a simultaneous byte load.
REQ-016 Latency SHALL be: the first tx_valid arrives on the first bit_en strictly after the IDLE load cycle; an N-byte packet emits exactly 8N+16 tx_valid pulses.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE, r=0xFFFF, sh=0, count=0, c=0, and tx_bit, tx_valid, tx_eop, underrun and busy SHALL all be 0.
REQ-018 Reset asserted mid-packet SHALL take effect immediately with no further tx_valid; after release the block SHALL start cleanly at the next in_valid.

Configuration
REQ-019 Macro CRC16_CHECK_EN SHALL control a loopback checker.
REQ-020 With CRC16_CHECK_EN defined, the block SHALL add inputs rx_bit, rx_valid, rx_eop (1 bit each) and outputs crc_ok, crc_err (1-cycle pulses).
REQ-021 The checker register SHALL be set to 0xFFFF on the first rx_valid after IDLE or rx_eop, and updated per REQ-004 on each rx_valid.
REQ-022 On rx_eop, the checker SHALL pulse crc_ok if the register equals 0xB001, or crc_err otherwise, in the next cycle.
REQ-023 Without CRC16_CHECK_EN, those checker ports and logic SHALL be absent and the TX behaviour SHALL be identical.

Verification
REQ-024 Bench SHALL cover: single byte 0x00, in_last=1, bit_en=1 constantly -> 24 bits: 00000000, then 0x40 LSB-first (00000010), then 0xBF LSB-first (11111101), then tx_eop pulse.
REQ-025 Bench SHALL cover: ASCII "123456789" streamed back-to-back -> CRC bits form 0xB4C8, low byte first, and tx_valid count = 88.
REQ-026 Bench SHALL cover: bit_en every 4th cycle, 2 bytes 0xD5, 0x00 -> 32 tx_valid pulses spaced 4 cycles apart, with tx_bit stable between them.
REQ-027 Bench SHALL cover: 2-byte packet with in_valid held low at the first byte boundary -> underrun pulse, no tx_eop, busy=0, and the next packet is correct.
REQ-028 Bench SHALL cover: abort asserted, or rst_n pulsed, mid-CRC -> tx_valid stops on the next cycle, no tx_eop, all outputs at reset values.
REQ-029 Bench SHALL cover: with CRC16_CHECK_EN, tx_bit/tx_valid/tx_eop looped to rx_* -> crc_ok; with one data bit flipped -> crc_err.
